// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer for the EX stage.
// Owns HI/LO and executes MULT, MULTU, DIV, DIVU (32 CALC iterations plus one SIGN
// cycle) and MTHI/MTLO (single-cycle writes from IDLE).
// Optional build macro MDU_EARLY_OUT_EN: multiplies leave CALC as soon as the
// remaining multiplier magnitude bits are all zero. Results are unchanged.
module mdu_seq #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned CntW = $clog2(DATA_W);

  typedef enum logic [1:0] {StIdle, StCalc, StSign} state_e;

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic                    busy_q;
  logic                    done_q;
  logic [DATA_W-1:0]       hi_q;
  logic [DATA_W-1:0]       lo_q;
  logic                    is_div_q;
  logic                    neg_q;      // product/quotient needs negation
  logic                    rem_neg_q;  // dividend was negative
  logic                    div0_q;
  // mul: running product;   div: remainder in the low half
  logic [2*DATA_W-1:0]     acc_q;
  // mul: shifted multiplicand; div: divisor in the low half
  logic [2*DATA_W-1:0]     mcand_q;
  // mul: remaining multiplier; div: dividend shifting out, quotient shifting in
  logic [DATA_W-1:0]       shreg_q;

  logic                    op_signed;
  logic                    op_is_div;
  logic                    op_arith;
  logic                    a_neg;
  logic                    b_neg;
  logic [DATA_W-1:0]       a_mag;
  logic [DATA_W-1:0]       b_mag;
  logic [2*DATA_W-1:0]     mul_acc;
  logic [DATA_W:0]         div_shift;
  logic [DATA_W:0]         div_diff;
  logic                    div_ok;
  logic                    calc_last;
  logic [2*DATA_W-1:0]     prod_fix;
  logic [DATA_W-1:0]       quo_fix;
  logic [DATA_W-1:0]       rem_fix;

  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = busy_q | (start & op_arith & (state_q == StIdle));

  // Operand decode and magnitude extraction for the accept edge.
  always_comb begin
    op_arith  = ~op[2];
    op_signed = ~op[0];
    op_is_div = op[1];
    a_neg     = op_signed & src_a[DATA_W-1];
    b_neg     = op_signed & src_b[DATA_W-1];
    a_mag     = a_neg ? -src_a : src_a;
    b_mag     = b_neg ? -src_b : src_b;
  end

  // One shift-add / restoring-divide step, plus the exit condition of CALC.
  always_comb begin
    mul_acc   = acc_q + (shreg_q[0] ? mcand_q : '0);
    div_shift = {acc_q[DATA_W-1:0], shreg_q[DATA_W-1]};
    div_diff  = div_shift - {1'b0, mcand_q[DATA_W-1:0]};
    div_ok    = ~div_diff[DATA_W];
    calc_last = (cnt_q == CntW'(DATA_W - 1));
`ifdef MDU_EARLY_OUT_EN
    if (!is_div_q && (shreg_q[DATA_W-1:1] == '0)) begin
      calc_last = 1'b1;
    end
`endif
  end

  // Sign correction applied in SIGN; divide-by-zero forces an all-ones quotient.
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = div0_q ? '1 : (neg_q ? -shreg_q : shreg_q);
    rem_fix  = rem_neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
  end

  // Sequencer FSM with registered HI/LO, busy and done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      shreg_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // flush blocks every kind of accept, including MTHI/MTLO
          if (start && !flush) begin
            if (op_arith) begin
              state_q   <= StCalc;
              busy_q    <= 1'b1;
              cnt_q     <= '0;
              is_div_q  <= op_is_div;
              neg_q     <= a_neg ^ b_neg;
              rem_neg_q <= a_neg;
              div0_q    <= op_is_div & (src_b == '0);
              acc_q     <= '0;
              if (op_is_div) begin
                mcand_q <= {{DATA_W{1'b0}}, b_mag};
                shreg_q <= a_mag;
              end else begin
                mcand_q <= {{DATA_W{1'b0}}, a_mag};
                shreg_q <= b_mag;
              end
            end else if (op == 3'd4) begin
              hi_q <= src_a;
            end else if (op == 3'd5) begin
              lo_q <= src_a;
            end
          end
        end
        StCalc: begin
          if (flush) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
            if (is_div_q) begin
              acc_q   <= {{DATA_W{1'b0}},
                          (div_ok ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0])};
              shreg_q <= {shreg_q[DATA_W-2:0], div_ok};
            end else begin
              acc_q   <= mul_acc;
              mcand_q <= {mcand_q[2*DATA_W-2:0], 1'b0};
              shreg_q <= {1'b0, shreg_q[DATA_W-1:1]};
            end
            if (calc_last) begin
              state_q <= StSign;
            end
          end
        end
        StSign: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          if (!flush) begin
            done_q <= 1'b1;
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*DATA_W-1:DATA_W];
              lo_q <= prod_fix[DATA_W-1:0];
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed testbench for mdu_seq (DATA_W = 32), hand-computed expected values.
module tb_mdu_seq;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk  = 0;
  int n_pass = 0;

  mdu_seq #(.DATA_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Cycle index (accept cycle = 0) of the done cycle.
  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] b);
    int          n;
    logic [31:0] m;
    n = 32;
    m = b;
`ifdef MDU_EARLY_OUT_EN
    if (o == OpMult || o == OpMultu) begin
      if (o == OpMult && b[31]) m = -b;
      n = 1;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    end
`endif
    return n + 2;
  endfunction

  // Called at a negedge; presents the op, leaves start high, scrambles operands after E0.
  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    #1;
    check_eq("stall_on_accept", {63'd0, stall}, 64'd1);
    @(posedge clk);
    #1;
    src_a = ~a;
    src_b = ~b;
  endtask

  // Waits for done (bounded), drops start at cycle 'hold', then checks results and timing.
  task automatic wait_done(input string tag, input int lat, input int hold,
                           input logic [31:0] ehi, input logic [31:0] elo);
    int cyc  = 0;
    int scnt = 1;
    int h;
    bit got  = 1'b0;
    h = (hold < lat) ? hold : 1;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == h) start = 1'b0;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (stall) scnt++;
    end
    check_eq({tag, "_done_seen"}, {63'd0, got}, 64'd1);
    check_eq({tag, "_latency"}, 64'(cyc), 64'(lat));
    check_eq({tag, "_stall_cycles"}, 64'(scnt), 64'(lat));
    check_eq({tag, "_stall_low_done"}, {63'd0, stall}, 64'd0);
    check_eq({tag, "_busy_low_done"}, {63'd0, busy}, 64'd0);
    check_eq({tag, "_hi"}, {32'd0, hi}, {32'd0, ehi});
    check_eq({tag, "_lo"}, {32'd0, lo}, {32'd0, elo});
  endtask

  initial begin
    int dcnt;
    resetn = 1'b0;
    start  = 1'b0;
    op     = 3'd0;
    src_a  = '0;
    src_b  = '0;
    flush  = 1'b0;
    #12;
    check_eq("rst_hi", {32'd0, hi}, 64'd0);
    check_eq("rst_lo", {32'd0, lo}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Signed multiply with start held (ignored while busy) and operands scrambled.
    start_op(OpMult, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_done("mult", exp_lat(OpMult, 32'h3), 20, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // MULTU full width, then DIVU accepted in its done cycle.
    start_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu", exp_lat(OpMultu, 32'hFFFF_FFFF), 1, 32'hFFFF_FFFE, 32'h0000_0001);
    start_op(OpDivu, 32'd100, 32'd7);
    wait_done("divu_b2b", 34, 1, 32'd2, 32'd14);

    @(negedge clk);
    start_op(OpDiv, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 34, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    @(negedge clk);
    start_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 34, 1, 32'h0, 32'h8000_0000);
    @(negedge clk);
    start_op(OpDivu, 32'h1234_5678, 32'h0);
    wait_done("divu_zero", 34, 1, 32'h1234_5678, 32'hFFFF_FFFF);
    @(negedge clk);
    start_op(OpDiv, 32'hFFFF_FFF9, 32'h0);
    wait_done("div_zero", 34, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // Multiplier 1 and 0 (early-out cases when enabled).
    @(negedge clk);
    start_op(OpMultu, 32'hDEAD_BEEF, 32'd1);
    wait_done("multu_b1", exp_lat(OpMultu, 32'd1), 1, 32'h0, 32'hDEAD_BEEF);
    @(negedge clk);
    start_op(OpMultu, 32'h1234, 32'd0);
    wait_done("multu_b0", exp_lat(OpMultu, 32'd0), 1, 32'h0, 32'h0);

    // MTLO then MTHI: no stall, written at the next edge.
    @(negedge clk);
    start = 1'b1;
    op    = OpMtlo;
    src_a = 32'hA5A5_A5A5;
    #1;
    check_eq("mtlo_no_stall", {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1;
    check_eq("mtlo_lo", {32'd0, lo}, 64'hA5A5_A5A5);
    op    = OpMthi;
    src_a = 32'h5A5A_5A5A;
    #1;
    check_eq("mthi_no_stall", {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("mthi_hi", {32'd0, hi}, 64'h5A5A_5A5A);
    check_eq("mthi_busy", {63'd0, busy}, 64'd0);
    check_eq("mthi_done", {63'd0, done}, 64'd0);

    // Flush of an in-flight MULT at cycle 10.
    @(negedge clk);
    start_op(OpMult, 32'd7, 32'd9);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_eq("flush_busy", {63'd0, busy}, 64'd0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check_eq("flush_no_done", 64'(dcnt), 64'd0);
    check_eq("flush_hi", {32'd0, hi}, 64'h5A5A_5A5A);
    check_eq("flush_lo", {32'd0, lo}, 64'hA5A5_A5A5);

    // Flush together with start in IDLE: nothing accepted.
    start = 1'b1;
    op    = OpMult;
    src_a = 32'd3;
    src_b = 32'd3;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check_eq("flush_start_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check_eq("flush_start_stall", {63'd0, stall}, 64'd0);

    // Asynchronous reset mid-operation.
    start_op(OpMultu, 32'd3, 32'd5);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("arst_busy", {63'd0, busy}, 64'd0);
    check_eq("arst_hi", {32'd0, hi}, 64'd0);
    check_eq("arst_lo", {32'd0, lo}, 64'd0);
    check_eq("arst_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    start_op(OpMultu, 32'd3, 32'd5);
    wait_done("after_rst", exp_lat(OpMultu, 32'd5), 1, 32'd0, 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
